ratio_div_ctrl: RTL and testbench

- Downstream sequencer for the fixed-point reciprocal unit (inv_recip). Computes q = num / den in signed QF format (default Q16.16).
- Accepts (num, den) pairs on a valid/ready input and launches the reciprocal on den via its start/done handshake.
- Multiplies num by the returned reciprocal, then rounds and saturates the product.
- Presents the result on a valid/ready output with error and saturation flags. Used by the watchdog rate/ratio checks.

---
 rtl/ratio_pkg.sv | 28 ++
 rtl/ratio_div_ctrl_fx_round_sat.sv | 44 ++++
 rtl/ratio_div_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ratio_div_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ratio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ratio_pkg
// Purpose : Shared definitions for the ratio divider sequencer: default
//           fixed-point geometry, FSM state encoding and QF constants.
// Revision: 1.0  initial release
// ============================================================================
package ratio_pkg;

    localparam int RATIO_W = 32;
    localparam int RATIO_F = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_MUL    = 3'd3,
        S_SAT    = 3'd4,
        S_OUT    = 3'd5
    } state_e;

    localparam logic [RATIO_W-1:0] SAT_MAX    = {1'b0, {(RATIO_W-1){1'b1}}};
    localparam logic [RATIO_W-1:0] SAT_MIN    = {1'b1, {(RATIO_W-1){1'b0}}};
    localparam logic [RATIO_W-1:0] Q_ONE      = RATIO_W'(1) << RATIO_F;
    localparam logic [RATIO_W-1:0] Q_HALF_LSB = RATIO_W'(1) << (RATIO_F - 1);

endpackage : ratio_pkg
`default_nettype wire

// File: rtl/ratio_div_ctrl_fx_round_sat.sv
`default_nettype none
// ============================================================================
// Module  : fx_round_sat
// Purpose : Combinational round-half-up and saturate of a signed 2W-bit
//           QF*QF product back down to a signed W-bit QF word.
// Ports   : prod  - signed 2W-bit product (2F fractional bits)
//           q     - signed W-bit QF result
//           sat   - high when the rounded value was clipped
// Revision: 1.0  initial release
// ============================================================================
module fx_round_sat #(
    parameter int W = 32,
    parameter int F = 16
) (
    input  logic signed [2*W-1:0] prod,
    output logic        [W-1:0]   q,
    output logic                  sat
);

    // One extra bit so adding the half-LSB never wraps at the top of range.
    localparam logic signed [2*W:0] C_HALF = {{(2*W+1-F){1'b0}}, 1'b1, {(F-1){1'b0}}};
    localparam logic signed [2*W:0] C_MAX  = {{(W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W:0] C_MIN  = {{(W+2){1'b1}}, {(W-1){1'b0}}};

    logic signed [2*W:0] w_sum;
    logic signed [2*W:0] w_shift;

    assign w_sum   = {prod[2*W-1], prod} + C_HALF;
    assign w_shift = w_sum >>> F;

    always_comb begin
        q   = w_shift[W-1:0];
        sat = 1'b0;
        if (w_shift > C_MAX) begin
            q   = {1'b0, {(W-1){1'b1}}};
            sat = 1'b1;
        end else if (w_shift < C_MIN) begin
            q   = {1'b1, {(W-1){1'b0}}};
            sat = 1'b1;
        end
    end

endmodule : fx_round_sat
`default_nettype wire

// File: rtl/ratio_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ratio_div_ctrl
// Purpose : Sequencer computing q = num / den in signed QF by launching the
//           reciprocal unit on den, multiplying num by the reciprocal, then
//           rounding and saturating. One pair in flight at a time.
// Ports   : in_valid/in_ready/num_in/den_in   - input pair handshake
//           recip_start/recip_x               - launch of reciprocal unit
//           recip_done/recip_inv/recip_invalid - reciprocal answer
//           out_valid/out_ready/q_out/q_err/q_sat - result handshake
// Revision: 1.0  initial release
// ============================================================================
module ratio_div_ctrl
    import ratio_pkg::*;
#(
    parameter int W           = RATIO_W,
    parameter int F           = RATIO_F,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] num_in,
    input  logic [W-1:0] den_in,
    output logic         recip_start,
    output logic [W-1:0] recip_x,
    input  logic         recip_done,
    input  logic [W-1:0] recip_inv,
    input  logic         recip_invalid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] q_out,
    output logic         q_err,
    output logic         q_sat
);

    localparam int            CW         = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT_CYC - 1);

    state_e                state_q,     state_d;
    logic [W-1:0]          num_q,       num_d;
    logic [W-1:0]          x_q,         x_d;
    logic [W-1:0]          inv_q,       inv_d;
    logic                  invalid_q,   invalid_d;
    logic                  err_q,       err_d;
    logic [CW-1:0]         cnt_q,       cnt_d;
    logic                  drain_q,     drain_d;
    logic signed [2*W-1:0] prod_q,      prod_d;
    logic [W-1:0]          q_q,         q_d;
    logic                  q_err_q,     q_err_d;
    logic                  q_sat_q,     q_sat_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready_q,  in_ready_d;

    logic signed [2*W-1:0] w_num_ext;
    logic signed [2*W-1:0] w_inv_ext;
    logic signed [2*W-1:0] w_prod;
    logic [W-1:0]          w_rs_q;
    logic                  w_rs_sat;

    // The reciprocal is unsigned; zero-extending keeps it non-negative. The
    // true product always fits in 2W signed bits, so 2W-bit wrap is exact.
    assign w_num_ext = {{W{num_q[W-1]}}, num_q};
    assign w_inv_ext = {{W{1'b0}}, inv_q};
    assign w_prod    = w_num_ext * w_inv_ext;

    fx_round_sat #(
        .W (W),
        .F (F)
    ) u_round_sat (
        .prod (prod_q),
        .q    (w_rs_q),
        .sat  (w_rs_sat)
    );

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        x_d         = x_q;
        inv_d       = inv_q;
        invalid_d   = invalid_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        prod_d      = prod_q;
        q_d         = q_q;
        q_err_d     = q_err_q;
        q_sat_d     = q_sat_q;
        out_valid_d = out_valid_q;
        recip_start = 1'b0;

        // A late answer to a timed-out launch is swallowed wherever it lands.
        if (drain_q && recip_done) begin
            drain_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    num_d   = num_in;
                    x_d     = den_in;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                recip_start = 1'b1;
                cnt_d       = '0;
                err_d       = 1'b0;
                invalid_d   = 1'b0;
                inv_d       = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (recip_done) begin
                    inv_d     = recip_inv;
                    invalid_d = recip_invalid;
                    state_d   = S_MUL;
                end else if (cnt_q == C_CNT_LAST) begin
                    err_d   = 1'b1;
                    drain_d = 1'b1;
                    inv_d   = '0;
                    state_d = S_MUL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MUL: begin
                prod_d  = w_prod;
                state_d = S_SAT;
            end
            S_SAT: begin
                if (err_q || invalid_q) begin
                    q_d     = '0;
                    q_err_d = 1'b1;
                    q_sat_d = 1'b0;
                end else begin
                    q_d     = w_rs_q;
                    q_err_d = 1'b0;
                    q_sat_d = w_rs_sat;
                end
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered so it reads 0 throughout reset and tracks IDLE && !drain.
        in_ready_d = (state_d == S_IDLE) && !drain_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            x_q         <= '0;
            inv_q       <= '0;
            invalid_q   <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            prod_q      <= '0;
            q_q         <= '0;
            q_err_q     <= 1'b0;
            q_sat_q     <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            x_q         <= x_d;
            inv_q       <= inv_d;
            invalid_q   <= invalid_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            prod_q      <= prod_d;
            q_q         <= q_d;
            q_err_q     <= q_err_d;
            q_sat_q     <= q_sat_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign recip_x   = x_q;
    assign out_valid = out_valid_q;
    assign q_out     = q_q;
    assign q_err     = q_err_q;
    assign q_sat     = q_sat_q;

endmodule : ratio_div_ctrl
`default_nettype wire

// File: tb/tb_ratio_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ratio_div_ctrl
// Purpose : Self-checking bench for ratio_div_ctrl. The bench acts as the
//           reciprocal unit and predicts each quotient from num * inv with
//           plain 64-bit arithmetic.
// Revision: 1.0  initial release
// ============================================================================
module tb_ratio_div_ctrl;

    localparam int W  = 32;
    localparam int F  = 16;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] num_in;
    logic [W-1:0] den_in;
    logic         recip_start;
    logic [W-1:0] recip_x;
    logic         recip_done;
    logic [W-1:0] recip_inv;
    logic         recip_invalid;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] q_out;
    logic         q_err;
    logic         q_sat;

    int n_checks = 0;
    int n_errs   = 0;

    ratio_div_ctrl #(
        .W           (W),
        .F           (F),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .num_in        (num_in),
        .den_in        (den_in),
        .recip_start   (recip_start),
        .recip_x       (recip_x),
        .recip_done    (recip_done),
        .recip_inv     (recip_inv),
        .recip_invalid (recip_invalid),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .q_out         (q_out),
        .q_err         (q_err),
        .q_sat         (q_sat)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Quotient as the arithmetic defines it: round(num*inv / 2^F) half up,
    // clipped to the signed W-bit range; forced to an error result if bad.
    function automatic void model(input logic [31:0] num, input logic [31:0] inv, input bit bad,
                                  output logic [31:0] q, output bit e, output bit s);
        longint p;
        longint r;
        if (bad) begin
            q = 32'd0; e = 1'b1; s = 1'b0;
            return;
        end
        p = longint'($signed(num)) * longint'({32'd0, inv});
        r = (p + 64'sd32768) >>> 16;
        e = 1'b0;
        if (r > 64'sd2147483647) begin
            q = 32'h7FFF_FFFF; s = 1'b1;
        end else if (r < -64'sd2147483648) begin
            q = 32'h8000_0000; s = 1'b1;
        end else begin
            q = r[31:0]; s = 1'b0;
        end
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq({tag, "/ready_timeout"}, 64'd0, 64'd1);
    endtask

    // Full transaction with the bench answering as the reciprocal unit.
    task automatic run_txn(input logic [31:0] num, input logic [31:0] den, input logic [31:0] inv,
                           input bit inval, input int dly, input int hold, input string tag);
        logic [31:0] eq;
        bit ee, es;
        int lat;
        bit stable;
        model(num, inv, inval, eq, ee, es);
        wait_ready(tag);
        num_in   = num;
        den_in   = den;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, "/start"}, 64'(recip_start), 64'd1);
        check_eq({tag, "/x"}, 64'(recip_x), 64'(den));
        stable = 1'b1;
        repeat (dly) begin
            @(negedge clk);
            if (recip_x !== den || recip_start !== 1'b0) stable = 1'b0;
        end
        check_eq({tag, "/x_stable"}, 64'(stable), 64'd1);
        recip_done    = 1'b1;
        recip_inv     = inv;
        recip_invalid = inval;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            recip_done    = 1'b0;
            recip_invalid = 1'b0;
        end while (out_valid !== 1'b1 && lat < 20);
        check_eq({tag, "/latency"}, 64'(lat), 64'd3);
        check_eq({tag, "/q_out"}, 64'(q_out), 64'(eq));
        check_eq({tag, "/q_err"}, 64'(q_err), 64'(ee));
        check_eq({tag, "/q_sat"}, 64'(q_sat), 64'(es));
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (out_valid !== 1'b1 || q_out !== eq || q_err !== ee ||
                    q_sat !== es || in_ready !== 1'b0) stable = 1'b0;
            end
            check_eq({tag, "/hold"}, 64'(stable), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "/drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] rn, rd, ri;
        bit rb;

        rst_n         = 1'b0;
        in_valid      = 1'b0;
        num_in        = '0;
        den_in        = '0;
        recip_done    = 1'b0;
        recip_inv     = '0;
        recip_invalid = 1'b0;
        out_ready     = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst/in_ready", 64'(in_ready), 64'd0);
        check_eq("rst/out_valid", 64'(out_valid), 64'd0);
        check_eq("rst/q_out", {31'd0, q_err, q_sat, q_out}, 64'd0);
        check_eq("rst/recip", {31'd0, recip_start, recip_x}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst/in_ready", 64'(in_ready), 64'd1);

        // Directed cases
        run_txn(32'd196608, 32'd131072, 32'd32768, 1'b0, 10, 0, "pos");
        run_txn(32'hFFFD_0000, 32'd131072, 32'd32768, 1'b0, 3, 5, "neg_hold");
        run_txn(32'd1, 32'd131072, 32'd32768, 1'b0, 1, 0, "round_half");
        run_txn(32'h7FFF_0000, 32'h0000_4000, 32'h0004_0000, 1'b0, 2, 0, "sat_hi");
        run_txn(32'h8000_0000, 32'h0000_4000, 32'h0004_0000, 1'b0, 2, 0, "sat_lo");
        run_txn(32'd65536, 32'd0, 32'hDEAD_BEEF, 1'b1, 4, 0, "den_zero");
        run_txn(32'd65536, 32'd65536, 32'd65536, 1'b0, TO, 0, "done_last");

        // Stray recip_done while idle must not produce anything
        @(negedge clk);
        recip_done = 1'b1;
        recip_inv  = 32'h1234_5678;
        @(negedge clk);
        recip_done = 1'b0;
        @(negedge clk);
        check_eq("stray/out_valid", 64'(out_valid), 64'd0);
        check_eq("stray/in_ready", 64'(in_ready), 64'd1);

        // Timeout: no answer, error result, then drain until a late done
        wait_ready("timeout");
        num_in   = 32'd196608;
        den_in   = 32'd131072;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("timeout/start", 64'(recip_start), 64'd1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (out_valid !== 1'b1 && lat < 40);
        check_eq("timeout/latency", 64'(lat), 64'(TO + 3));
        check_eq("timeout/q_err", 64'(q_err), 64'd1);
        check_eq("timeout/q_out", {q_sat, q_out}, 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("drain/in_ready", 64'(in_ready), 64'd0);
        recip_done = 1'b1;
        @(negedge clk);
        recip_done = 1'b0;
        check_eq("drain/released", 64'(in_ready), 64'd1);
        check_eq("drain/out_valid", 64'(out_valid), 64'd0);

        // Randomized transactions against the model
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0: rn = $urandom;
                1: rn = 32'($signed($urandom_range(0, 2097152)) - 1048576);
                default: rn = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'($urandom)};
            endcase
            ri = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1 << 20));
            rd = $urandom;
            rb = ($urandom_range(0, 5) == 0);
            run_txn(rn, rd, ri, rb, $urandom_range(1, 12), $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        // Reset while waiting for the reciprocal
        wait_ready("rst_mid");
        num_in   = 32'd196608;
        den_in   = 32'd131072;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid/out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_mid/in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_mid/recip_x", 64'(recip_x), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_mid/idle", 64'(in_ready), 64'd1);
        repeat (5) @(negedge clk);
        check_eq("rst_mid/no_out", 64'(out_valid), 64'd0);
        run_txn(32'd196608, 32'd131072, 32'd32768, 1'b0, 2, 0, "after_rst");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_ratio_div_ctrl
`default_nettype wire
